// File: rtl/xlr8_pmem_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// State encoding, error codes and bus widths used by the loader and its checksum accumulator.
// No logic lives here.
package xlr8_pmem_loader_pkg;

  localparam int PM_WORD_W      = 16;
  localparam int PM_ADDR_FULL_W = 17;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_SIZE   = 2'd1;
  localparam logic [1:0] ERR_VERIFY = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY_RD,
    ST_VERIFY_CHK,
    ST_FIN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/xlr8_pmem_cksum.sv
// 16-bit clear/add accumulator (modulo 2^16) used for the image checksums.
// Latency: sum reflects clr/add one cycle later.
// No backpressure; clr has priority over add_en.
module xlr8_pmem_cksum
  import xlr8_pmem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic [PM_WORD_W-1:0] add_dat,
  output logic [PM_WORD_W-1:0] sum
);

  logic [PM_WORD_W-1:0] sum_q, sum_d;

  // next accumulator value: clear wins, otherwise wrap-around add
  always_comb begin
    sum_d = sum_q;
    if (clr)         sum_d = '0;
    else if (add_en) sum_d = sum_q + add_dat;
  end

  // accumulator register
  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/xlr8_pmem_loader.sv
// Streams 16-bit words into pmem from BASE_ADDR, holding the core in reset; optional readback verify
// (macro XLR8_PMEM_LOADER_VERIFY_EN). Latency: pm_* strobe 1 cycle after each src handshake.
// Backpressure: src_ready high only in WRITE with words remaining; src_valid low stalls pm_ce.
module xlr8_pmem_loader
  import xlr8_pmem_loader_pkg::*;
#(
  parameter int                        PM_SIZE   = 16,
  parameter logic [PM_ADDR_FULL_W-1:0] BASE_ADDR = '0
) (
  input  logic                      clk,
  input  logic                      rst_flash,
  input  logic                      start,
  input  logic [PM_ADDR_FULL_W-1:0] load_words,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err_code,
  output logic                      core_hold,
  input  logic                      src_valid,
  input  logic [PM_WORD_W-1:0]      src_data,
  output logic                      src_ready,
  output logic                      pm_ce,
  output logic                      pm_wr,
  output logic [PM_ADDR_FULL_W-1:0] pm_addr,
  output logic [PM_WORD_W-1:0]      pm_wr_data,
  input  logic [PM_WORD_W-1:0]      pm_rd_data
);

  // one extra bit so BASE_ADDR + load_words cannot wrap before the capacity compare
  localparam logic [PM_ADDR_FULL_W:0] PM_CAP = (PM_ADDR_FULL_W+1)'(PM_SIZE * 1024);

  state_e                      state_q, state_d;
  logic [PM_ADDR_FULL_W-1:0]   remaining_q, remaining_d;
  logic [PM_ADDR_FULL_W-1:0]   addr_q, addr_d;
  logic                        pm_ce_q, pm_ce_d, pm_wr_q, pm_wr_d;
  logic [PM_ADDR_FULL_W-1:0]   pm_addr_q, pm_addr_d;
  logic [PM_WORD_W-1:0]        pm_wr_data_q, pm_wr_data_d;
  logic                        done_q, done_d, busy_q, busy_d, core_hold_q, core_hold_d;
  logic [1:0]                  err_q, err_d;
  logic                        start_acc, hs;
  logic [PM_ADDR_FULL_W:0]     end_addr;
  logic [PM_WORD_W-1:0]        sum16;

`ifdef XLR8_PMEM_LOADER_VERIFY_EN
  logic [PM_ADDR_FULL_W-1:0]   words_q, words_d;
  logic                        rd_vld_q;
  logic [PM_WORD_W-1:0]        rsum16;
`else
  // readback data and the write checksum have no consumer without the verify pass
  logic unused_inputs;
  assign unused_inputs = ^{pm_rd_data, sum16};
`endif

  assign src_ready = (state_q == ST_WRITE) && (remaining_q != '0);
  assign hs        = src_valid && src_ready;
  assign end_addr  = {1'b0, BASE_ADDR} + {1'b0, load_words};

  // next-state and registered-output computation for the load/verify sequencer
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    addr_d       = addr_q;
    pm_ce_d      = 1'b0;
    pm_wr_d      = 1'b0;
    pm_addr_d    = pm_addr_q;
    pm_wr_data_d = pm_wr_data_q;
    done_d       = done_q;
    err_d        = err_q;
    start_acc    = 1'b0;
`ifdef XLR8_PMEM_LOADER_VERIFY_EN
    words_d      = words_q;
`endif
    case (state_q)
      ST_WRITE: begin
        if (hs) begin
          pm_ce_d      = 1'b1;
          pm_wr_d      = 1'b1;
          pm_addr_d    = addr_q;
          pm_wr_data_d = src_data;
          addr_d       = addr_q + 1'b1;
          remaining_d  = remaining_q - 1'b1;
          if (remaining_q == PM_ADDR_FULL_W'(1)) begin
`ifdef XLR8_PMEM_LOADER_VERIFY_EN
            state_d     = ST_VERIFY_RD;
            addr_d      = BASE_ADDR;
            remaining_d = words_q;
`else
            state_d     = ST_FIN;
            done_d      = 1'b1;
`endif
          end
        end
      end
`ifdef XLR8_PMEM_LOADER_VERIFY_EN
      ST_VERIFY_RD: begin
        pm_ce_d     = 1'b1;
        pm_addr_d   = addr_q;
        addr_d      = addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == PM_ADDR_FULL_W'(1)) state_d = ST_VERIFY_CHK;
      end
      ST_VERIFY_CHK: begin
        // the last read strobe and its data beat have both drained, so rsum16 is final
        if (!pm_ce_q && !rd_vld_q) begin
          if (rsum16 == sum16) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_VERIFY;
          end
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: ;
    endcase

    // a new load may begin whenever nothing is in flight; ignored while busy
    if (start && (state_q inside {ST_IDLE, ST_FIN, ST_ERR})) begin
      start_acc   = 1'b1;
      done_d      = 1'b0;
      err_d       = ERR_NONE;
      remaining_d = load_words;
      addr_d      = BASE_ADDR;
      state_d     = ST_IDLE;
`ifdef XLR8_PMEM_LOADER_VERIFY_EN
      words_d     = load_words;
`endif
      if (end_addr > PM_CAP) begin
        state_d = ST_ERR;
        err_d   = ERR_SIZE;
      end else if (load_words == '0) begin
        state_d = ST_FIN;
        done_d  = 1'b1;
      end else begin
        state_d = ST_WRITE;
      end
    end

    busy_d      = state_d inside {ST_WRITE, ST_VERIFY_RD, ST_VERIFY_CHK};
    core_hold_d = busy_d;
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst_flash) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      addr_q       <= BASE_ADDR;
      pm_ce_q      <= 1'b0;
      pm_wr_q      <= 1'b0;
      pm_addr_q    <= BASE_ADDR;
      pm_wr_data_q <= '0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
      busy_q       <= 1'b0;
      core_hold_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      pm_ce_q      <= pm_ce_d;
      pm_wr_q      <= pm_wr_d;
      pm_addr_q    <= pm_addr_d;
      pm_wr_data_q <= pm_wr_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      core_hold_q  <= core_hold_d;
    end
  end

`ifdef XLR8_PMEM_LOADER_VERIFY_EN
  // word count for the readback pass, and a flag marking the beat where read data is valid
  always_ff @(posedge clk) begin
    if (rst_flash) begin
      words_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      words_q  <= words_d;
      rd_vld_q <= pm_ce_q && !pm_wr_q;
    end
  end

  xlr8_pmem_cksum u_rsum (
    .clk     (clk),
    .rst     (rst_flash),
    .clr     (start_acc),
    .add_en  (rd_vld_q),
    .add_dat (pm_rd_data),
    .sum     (rsum16)
  );
`endif

  xlr8_pmem_cksum u_sum (
    .clk     (clk),
    .rst     (rst_flash),
    .clr     (start_acc),
    .add_en  (hs),
    .add_dat (src_data),
    .sum     (sum16)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_code   = err_q;
  assign core_hold  = core_hold_q;
  assign pm_ce      = pm_ce_q;
  assign pm_wr      = pm_wr_q;
  assign pm_addr    = pm_addr_q;
  assign pm_wr_data = pm_wr_data_q;

endmodule

// File: tb/tb_xlr8_pmem_loader.sv
// Bench for xlr8_pmem_loader: directed loads with a write scoreboard checked by a negedge monitor.
// Covers reset, gapless/gapped streams, zero-length, size overflow, mid-load reset, ignored start
// and (with XLR8_PMEM_LOADER_VERIFY_EN) a corrupted readback.
module tb_xlr8_pmem_loader;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_flash = 1'b1;
  logic        start = 1'b0;
  logic [16:0] load_words = '0;
  logic        busy, done, core_hold, src_ready, pm_ce, pm_wr;
  logic [1:0]  err_code;
  logic        src_valid = 1'b0;
  logic [15:0] src_data = '0;
  logic [16:0] pm_addr;
  logic [15:0] pm_wr_data;
  logic [15:0] pm_rd_data = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  logic corrupt = 1'b0;
  wr_t exp_q[$];
  logic [15:0] mem [0:16383];

  xlr8_pmem_loader #(.PM_SIZE(16), .BASE_ADDR(17'd0)) dut (
    .clk        (clk),
    .rst_flash  (rst_flash),
    .start      (start),
    .load_words (load_words),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code),
    .core_hold  (core_hold),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .pm_ce      (pm_ce),
    .pm_wr      (pm_wr),
    .pm_addr    (pm_addr),
    .pm_wr_data (pm_wr_data),
    .pm_rd_data (pm_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pmem model: synchronous write, one-cycle read latency, optional corruption of word 2
  always @(posedge clk) begin
    if (pm_ce && pm_wr) mem[pm_addr[13:0]] <= pm_wr_data;
    if (pm_ce && !pm_wr)
      pm_rd_data <= mem[pm_addr[13:0]] ^ ((corrupt && pm_addr == 17'd2) ? 16'h0100 : 16'h0000);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (pm_ce && pm_wr) begin
      if (wr_seen == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=%0h/%0h required=none", pm_addr, pm_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(pm_addr), 32'(e.addr));
        chk("wr_data", 32'(pm_wr_data), 32'(e.dat));
      end
    end
    if (pm_ce && !pm_wr) rd_seen++;
  end

  task automatic do_start(input logic [16:0] n);
    start = 1'b1;
    load_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input logic [16:0] a, input bit gap);
    bit hs = 1'b0;
    bit got = 1'b0;
    if (gap) begin
      src_valid = 1'b0;
      @(posedge clk); #1;
    end
    src_valid = 1'b1;
    src_data = w;
    exp_q.push_back(wr_t'{addr: a, dat: w});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hs = src_ready;
      @(posedge clk); #1;
      if (hs) begin
        got = 1'b1;
        break;
      end
    end
    src_valid = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_stats();
    wr_seen = 0;
    rd_seen = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
  endtask

  task automatic load_four(input bit gaps);
    for (int i = 0; i < 4; i++) send(16'h1111 * 16'(i + 1), 17'(i), gaps && (i != 0));
  endtask

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hold", 32'(core_hold), 32'd0);
    chk("rst_ce", 32'(pm_ce), 32'd0);
    chk("rst_wr", 32'(pm_wr), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_addr", 32'(pm_addr), 32'd0);
    chk("rst_wdata", 32'(pm_wr_data), 32'd0);
    @(posedge clk); #1;
    rst_flash = 1'b0;

    // four words, no gaps: strobes on consecutive cycles
    clear_stats();
    do_start(17'd4);
    @(negedge clk);
    chk("t1_hold", 32'(core_hold), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    load_four(1'b0);
    wait_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err_code), 32'd0);
    chk("t1_wr_count", 32'(wr_seen), 32'd4);
    chk("t1_span", 32'(last_wr_cyc - first_wr_cyc), 32'd3);
    chk("t1_mem2", 32'(mem[2]), 32'h3333);
`ifdef XLR8_PMEM_LOADER_VERIFY_EN
    chk("t1_reads", 32'(rd_seen), 32'd4);
`endif

    // same load with a bubble before every word after the first
    clear_stats();
    do_start(17'd4);
    chk("t2_done_clr", 32'(done), 32'd0);
    load_four(1'b1);
    wait_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_wr_count", 32'(wr_seen), 32'd4);
    chk("t2_gapped", 32'(last_wr_cyc - first_wr_cyc > 3), 32'd1);
    for (int i = 0; i < 4; i++) chk("t2_mem", 32'(mem[i]), 32'(16'h1111 * 16'(i + 1)));

    // zero-length load
    clear_stats();
    do_start(17'd0);
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("t3_no_ce", 32'(wr_seen + rd_seen), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);

    // capacity overflow: 16385 words into a 16 KWord pmem
    clear_stats();
    do_start(17'd16385);
    @(negedge clk);
    chk("t4_err", 32'(err_code), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_no_ce", 32'(wr_seen + rd_seen), 32'd0);

`ifdef XLR8_PMEM_LOADER_VERIFY_EN
    // corrupted readback of word 2
    clear_stats();
    corrupt = 1'b1;
    do_start(17'd4);
    load_four(1'b0);
    wait_idle();
    @(negedge clk);
    chk("t5_err", 32'(err_code), 32'd2);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_reads", 32'(rd_seen), 32'd4);
    corrupt = 1'b0;
`endif

    // reset after two words, then a fresh three-word load
    clear_stats();
    do_start(17'd5);
    send(16'hBEE1, 17'd0, 1'b0);
    send(16'hBEE2, 17'd1, 1'b0);
    rst_flash = 1'b1;
    @(posedge clk); #1;
    rst_flash = 1'b0;
    @(negedge clk);
    chk("t6_ce_after_rst", 32'(pm_ce), 32'd0);
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    chk("t6_done_after_rst", 32'(done), 32'd0);
    chk("t6_partial_writes", 32'(wr_seen), 32'd2);
    @(posedge clk); #1;
    clear_stats();
    do_start(17'd3);
    for (int i = 0; i < 3; i++) send(16'hA001 + 16'(i), 17'(i), 1'b0);
    wait_idle();
    @(negedge clk);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_wr_count", 32'(wr_seen), 32'd3);

    // start pulsed mid-load must not disturb the word count
    clear_stats();
    do_start(17'd4);
    send(16'h0005, 17'd0, 1'b0);
    send(16'h0006, 17'd1, 1'b0);
    do_start(17'd1);
    send(16'h0007, 17'd2, 1'b0);
    send(16'h0008, 17'd3, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("t7_done", 32'(done), 32'd1);
    chk("t7_wr_count", 32'(wr_seen), 32'd4);
    chk("t7_ready_low", 32'(src_ready), 32'd0);
    chk("t7_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
